// File: rtl/lamp_safety_driver.sv
// Last stage before the lamp drivers: registers the four lamp codes, blocks illegal or
// conflicting patterns, and latches a flashing-red fault. Optional LAMP_FAULT_CLR_EN adds fault_clr.
module lamp_safety_driver #(
  parameter int unsigned STARTUP_CYC   = 4,
  parameter int unsigned FAULT_PERSIST = 2,
  parameter int unsigned FLASH_HALF    = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef LAMP_FAULT_CLR_EN
  input  logic       fault_clr,
`endif
  input  logic [2:0] light_M1_i,
  input  logic [2:0] light_S_i,
  input  logic [2:0] light_MT_i,
  input  logic [2:0] light_M2_i,
  output logic [2:0] lamp_M1_o,
  output logic [2:0] lamp_S_o,
  output logic [2:0] lamp_MT_o,
  output logic [2:0] lamp_M2_o,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned PW = $clog2(FAULT_PERSIST + 1);
  localparam int unsigned FW = $clog2(FLASH_HALF) + 1;
  localparam int unsigned SW = $clog2(STARTUP_CYC + 1);

  localparam logic [PW-1:0] PERSIST_MAX  = PW'(FAULT_PERSIST);
  localparam logic [PW-1:0] PERSIST_LAST = PW'(FAULT_PERSIST - 1);
  localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_HALF - 1);
  localparam logic [SW-1:0] STARTUP_LAST = SW'(STARTUP_CYC - 1);

  localparam logic [2:0]       RED      = 3'b100;
  localparam logic [3:0][2:0]  ALL_RED  = {4{RED}};

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_NORMAL,
    ST_FAULT
  } state_t;

  // Index map for packed lamp vectors: [3]=M1, [2]=S, [1]=MT, [0]=M2
  logic [3:0][2:0] r_in_q;
  logic [3:0][2:0] r_lamp;
  state_t          r_state;
  logic [PW-1:0]   r_persist;
  logic [FW-1:0]   r_flash;
  logic            r_flash_on;
  logic [SW-1:0]   r_startup;
  logic            r_fault;
  logic [1:0]      r_fault_code;

  logic            w_v1;
  logic            w_v2;
  logic            w_v3;
  logic            w_viol;
  logic [1:0]      w_vcode;
  logic            w_clr;

`ifdef LAMP_FAULT_CLR_EN
  assign w_clr = fault_clr;
`else
  assign w_clr = 1'b0;
`endif

  function automatic logic f_code_ok(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  always_comb begin
    w_v1 = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!f_code_ok(r_in_q[i])) w_v1 = 1'b1;
    end
    w_v2 = (r_in_q[2] != RED) &&
           ((r_in_q[3] != RED) || (r_in_q[1] != RED) || (r_in_q[0] != RED));
    w_v3 = (r_in_q[1] != RED) && (r_in_q[0] != RED);
    w_viol = w_v1 | w_v2 | w_v3;
    if (w_v1)      w_vcode = 2'd1;
    else if (w_v2) w_vcode = 2'd2;
    else if (w_v3) w_vcode = 2'd3;
    else           w_vcode = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_q       <= ALL_RED;
      r_lamp       <= ALL_RED;
      r_state      <= ST_STARTUP;
      r_persist    <= '0;
      r_flash      <= '0;
      r_flash_on   <= 1'b1;
      r_startup    <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= '0;
    end else begin
      r_in_q <= {light_M1_i, light_S_i, light_MT_i, light_M2_i};
      case (r_state)
        ST_STARTUP, ST_NORMAL: begin
          if (!w_viol)                        r_persist <= '0;
          else if (r_persist != PERSIST_MAX)  r_persist <= r_persist + PW'(1);
          // Fault entry is checked first so it beats a coincident startup expiry
          if (w_viol && (r_persist == PERSIST_LAST)) begin
            r_state      <= ST_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= w_vcode;
            r_lamp       <= ALL_RED;
            r_flash      <= '0;
            r_flash_on   <= 1'b1;
            r_persist    <= '0;
          end else if (r_state == ST_STARTUP) begin
            r_lamp <= ALL_RED;
            if (r_startup == STARTUP_LAST) r_state   <= ST_NORMAL;
            else                           r_startup <= r_startup + SW'(1);
          end else if (!w_viol) begin
            r_lamp <= r_in_q;
          end
        end
        ST_FAULT: begin
          r_persist <= '0;
          if (w_clr && !w_viol) begin
            r_state      <= ST_STARTUP;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_startup    <= '0;
            r_lamp       <= ALL_RED;
            r_flash      <= '0;
            r_flash_on   <= 1'b1;
          end else if (r_flash == FLASH_LAST) begin
            r_flash    <= '0;
            r_flash_on <= !r_flash_on;
            r_lamp     <= r_flash_on ? '0 : ALL_RED;
          end else begin
            r_flash <= r_flash + FW'(1);
          end
        end
        default: r_state <= ST_STARTUP;
      endcase
    end
  end

  assign lamp_M1_o  = r_lamp[3];
  assign lamp_S_o   = r_lamp[2];
  assign lamp_MT_o  = r_lamp[1];
  assign lamp_M2_o  = r_lamp[0];
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_lamp_safety_driver.sv
// Bench for lamp_safety_driver: table of legal/glitch vectors plus hand-built fault,
// priority, clear and startup-collision sequences, checked through an expectation queue.
module tb_lamp_safety_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] light_M1_i, light_S_i, light_MT_i, light_M2_i;
  logic [2:0] lamp_M1_o, lamp_S_o, lamp_MT_o, lamp_M2_o;
  logic       fault;
  logic [1:0] fault_code;
`ifdef LAMP_FAULT_CLR_EN
  logic       fault_clr = 1'b0;
`endif

  lamp_safety_driver #(
    .STARTUP_CYC   (4),
    .FAULT_PERSIST (2),
    .FLASH_HALF    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef LAMP_FAULT_CLR_EN
    .fault_clr  (fault_clr),
`endif
    .light_M1_i (light_M1_i),
    .light_S_i  (light_S_i),
    .light_MT_i (light_MT_i),
    .light_M2_i (light_M2_i),
    .lamp_M1_o  (lamp_M1_o),
    .lamp_S_o   (lamp_S_o),
    .lamp_MT_o  (lamp_MT_o),
    .lamp_M2_o  (lamp_M2_o),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [11:0] lamps;
    logic        flt;
    logic [1:0]  code;
    int          tag;
  } exp_t;

  typedef struct {
    logic [11:0] in;
    logic [11:0] exp;
  } vec_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        tbl[12];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] got;

  localparam logic [11:0] RED4 = 12'b100_100_100_100;
  localparam logic [11:0] DARK = 12'b000_000_000_000;

  assign got = {lamp_M1_o, lamp_S_o, lamp_MT_o, lamp_M2_o};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pat(input logic [2:0] m1, input logic [2:0] s,
                                      input logic [2:0] mt, input logic [2:0] m2);
    return {m1, s, mt, m2};
  endfunction

  task automatic push(input int due, input logic [11:0] l, input logic f,
                      input logic [1:0] c, input int tag);
    exp_t x;
    x.due = due; x.lamps = l; x.flt = f; x.code = c; x.tag = tag;
    sb.push_back(x);
  endtask

  // Expected flashing: red for 4 cycles from the entry edge, then dark for 4, repeating
  task automatic push_flash(input int from, input int to, input logic [1:0] c,
                            input int tag, input int entry);
    for (int d = from; d <= to; d++)
      push(d, (((d - entry) / 4) % 2 == 0) ? RED4 : DARK, 1'b1, c, tag);
  endtask

  task automatic chk_now(input int tag, input logic [11:0] l, input logic f, input logic [1:0] c);
    checks++;
    if (got !== l || fault !== f || fault_code !== c) begin
      errors++;
      $display("FAIL now tag%0d lamps=%h fault=%b code=%0d want lamps=%h fault=%b code=%0d",
               tag, got, fault, fault_code, l, f, c);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc || got !== e.lamps || fault !== e.flt || fault_code !== e.code) begin
        errors++;
        $display("FAIL sb tag%0d due=%0d cyc=%0d lamps=%h fault=%b code=%0d want lamps=%h fault=%b code=%0d",
                 e.tag, e.due, cyc, got, fault, fault_code, e.lamps, e.flt, e.code);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] v);
    {light_M1_i, light_S_i, light_MT_i, light_M2_i} = v;
  endtask

  task automatic startup(input logic [11:0] p, input int tag);
    int c0;
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 4; k++) push(c0 + k, RED4, 1'b0, 2'd0, tag);
    push(c0 + 5, p, 1'b0, 2'd0, tag);
    repeat (5) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] p1, p2, p3, p4, p5, p6, conf, prio, v3pat, badc, glv1, glv3;
    int c, c0;
    p1    = pat(3'b001, 3'b100, 3'b100, 3'b001);
    p2    = pat(3'b001, 3'b100, 3'b100, 3'b010);
    p3    = pat(3'b001, 3'b100, 3'b001, 3'b100);
    p4    = pat(3'b010, 3'b100, 3'b010, 3'b100);
    p5    = pat(3'b100, 3'b001, 3'b100, 3'b100);
    p6    = pat(3'b100, 3'b010, 3'b100, 3'b100);
    conf  = pat(3'b001, 3'b001, 3'b100, 3'b100);
    prio  = pat(3'b001, 3'b001, 3'b100, 3'b011);
    v3pat = pat(3'b100, 3'b100, 3'b001, 3'b010);
    badc  = pat(3'b111, 3'b100, 3'b100, 3'b100);
    glv1  = pat(3'b001, 3'b100, 3'b100, 3'b000);
    glv3  = pat(3'b100, 3'b100, 3'b001, 3'b001);

    // One-cycle violations must freeze the previous legal pattern
    tbl[0]  = '{p1, p1};
    tbl[1]  = '{p2, p2};
    tbl[2]  = '{p3, p3};
    tbl[3]  = '{p4, p4};
    tbl[4]  = '{p5, p5};
    tbl[5]  = '{p6, p6};
    tbl[6]  = '{conf, p6};
    tbl[7]  = '{p1, p1};
    tbl[8]  = '{glv1, p1};
    tbl[9]  = '{p3, p3};
    tbl[10] = '{glv3, p3};
    tbl[11] = '{p4, p4};

    drive(p1);
    #1 rst = 1'b1;
    #1 chk_now(1, RED4, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    startup(p1, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      push(cyc + 2, tbl[i].exp, 1'b0, 2'd0, 100 + i);
      step();
    end

    // Persistent side/main conflict; later input changes must not matter
    c = cyc;
    drive(conf);
    push(c + 2, p4, 1'b0, 2'd0, 3);
    push_flash(c + 3, c + 14, 2'd2, 3, c + 3);
    repeat (2) step();
    drive(p2);
    repeat (2) step();
    drive(badc);
    while (cyc < c + 15) step();

    #2 rst = 1'b1;
    #1 chk_now(4, RED4, 1'b0, 2'd0);
    drive(p1);
    startup(p1, 5);

    c = cyc;
    drive(prio);
    push(c + 2, p1, 1'b0, 2'd0, 6);
    push_flash(c + 3, c + 6, 2'd1, 6, c + 3);
    while (cyc < c + 7) step();
    rst = 1'b1;
    #1 chk_now(7, RED4, 1'b0, 2'd0);
    drive(p1);
    startup(p1, 7);

    c = cyc;
    drive(v3pat);
    push(c + 2, p1, 1'b0, 2'd0, 8);
`ifdef LAMP_FAULT_CLR_EN
    push_flash(c + 3, c + 8, 2'd3, 8, c + 3);
    for (int k = 9; k <= 13; k++) push(c + k, RED4, 1'b0, 2'd0, 8);
    push(c + 14, p1, 1'b0, 2'd0, 8);
    repeat (4) step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    drive(p1);
    repeat (3) step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    while (cyc < c + 15) step();
`else
    push_flash(c + 3, c + 16, 2'd3, 8, c + 3);
    repeat (4) step();
    drive(p1);
    while (cyc < c + 17) step();
`endif

    // Fault condition on the same edge as startup expiry
    rst = 1'b1;
    #1 chk_now(9, RED4, 1'b0, 2'd0);
    drive(p1);
    @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 3; k++) push(c0 + k, RED4, 1'b0, 2'd0, 10);
    push_flash(c0 + 4, c0 + 9, 2'd2, 10, c0 + 4);
    step();
    drive(conf);
    while (cyc < c0 + 10) step();

    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
